div_iter: RTL and testbench
===========================

# div_iter

Parametrised sequential integer divider, the successor to the fixed 32-bit `div` block. Computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, in signed or unsigned mode selected per operation. It uses a restoring shift-subtract datapath, one quotient bit per cycle. It sits behind the PRNG/arith datapath and uses valid/ready handshakes on both sides, so upstream and downstream logic can stall it.

## Interface
- `WIDTH`, 32: operand/result width in bits; legal range 4..64.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous abort; discards any operation in flight.
- `in_valid`  in  1  operands presented.
- `in_ready`  out  1  block can accept operands.
- `in_signed`  in  1  1 = two's-complement operands, 0 = unsigned.
- `dividend`  in  WIDTH  numerator (y).
- `divisor`  in  WIDTH  denominator (x).
- `out_valid`  out  1  result held on outputs.
- `out_ready`  in  1  consumer takes result.
- `q`  out  WIDTH  quotient.
- `r`  out  WIDTH  remainder.
- `dz`  out  1  divide-by-zero flag for this result.

## Operation
- States: IDLE, BUSY, FIXUP, DONE.
- `in_ready` = (state == IDLE). `out_valid` = (state == DONE).
- IDLE, accept (`in_valid & in_ready`):
  - Latch sign flags: neg_q = signed & (sign(y) ^ sign(x)); neg_r = signed & sign(y).
  - Latch magnitudes: |y|, |x| when signed, raw values when unsigned.
  - Clear the partial remainder (WIDTH+1 bits) and the bit counter.
  - If divisor == 0, go to DONE. Otherwise go to BUSY.
- BUSY, each cycle: shift {rem, quo} left by 1 and trial-subtract |x|. If the result is non-negative, keep it and set quo[0]=1; otherwise restore. After WIDTH cycles, go to FIXUP.
- FIXUP: q = neg_q ? -quo : quo; r = neg_r ? -rem : rem. Negation is modulo 2^WIDTH. Then go to DONE.
- DONE: hold q, r, dz stable. When `out_ready` is high, go to IDLE.
- Result semantics:
  - Signed quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Invariant: y == q*x + r (mod 2^WIDTH).
- Overflow case: signed most-negative / -1 gives q = most-negative, r = 0. No flag is raised.
- Divide by zero: q = all ones, r = dividend (unmodified input), dz = 1. `in_signed` does not change this result.
- `flush` (sync, any state): go to IDLE; `out_valid` drops the next cycle. `flush` takes priority over accept and over `out_ready`.
- Operands are not required to stay stable after the accept edge.

## Timing
- Reset (async assert, sync release):
  - state = IDLE, so `in_ready`=1 and `out_valid`=0.
  - q=0, r=0, dz=0, counter=0.
- Normal latency:
  - Accept edge, then WIDTH BUSY edges, then one FIXUP edge.
  - `out_valid` rises on the WIDTH+2th edge after accept (WIDTH=32: 34 edges).
- Divide-by-zero latency: `out_valid` rises on the edge after accept.
- Minimum throughput:
  - Issue interval is WIDTH+3 cycles, with `out_ready` tied high.
  - The DONE→IDLE edge costs one cycle; `in_ready` is low in DONE.
- Stalls: `out_ready` low in DONE holds outputs indefinitely. No back-pressure applies during BUSY.
- `rst_n` asserted mid-BUSY aborts immediately. Outputs go to reset values asynchronously.
- Outputs q/r/dz change only on the FIXUP→DONE edge or the zero-divisor accept edge. They remain valid after DONE until the next result or reset.

## Structure
- Package `div_pkg` holds:
  - The state enum `div_state_t` (IDLE, BUSY, FIXUP, DONE).
  - Localparam `DIV_CNT_W` = $clog2(WIDTH+1).
  - Helper functions `abs_w`/`neg_w` for sign pre/post-processing.
- No sub-module. The shift-subtract step is a single always block in `div_iter`.

## Test plan
- WIDTH=32, unsigned: 100 / 7 → q=14, r=2. `out_valid` on the 34th edge after accept; `dz`=0.
- WIDTH=32, signed: -7 / 2 → q=-3 (0xFFFFFFFD), r=-1. Then 7 / -2 → q=-3, r=1. Then 0x80000000 / -1 → q=0x80000000, r=0.
- WIDTH=8:
  - Unsigned 200 / 0 → q=0xFF, r=200, dz=1, `out_valid` one edge after accept.
  - Then unsigned 255 / 1 → q=255, r=0.
- Handshake: hold `out_ready`=0 for 10 cycles in DONE → q/r stable and `in_ready`=0. Release → IDLE next edge, and a second operation is accepted.
- `flush` pulsed mid-BUSY → IDLE next edge and `out_valid` never rises. A following 9/3 → q=3, r=0.
- `rst_n` low mid-BUSY → outputs 0 and `in_ready`=1 immediately. Then random signed/unsigned operands, WIDTH 8 and 32, checked against a reference model (1000 ops).

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider: state encoding, counter width,
// and modulo-2^w sign pre/post-processing on a 64-bit carrier.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_t;

  // Counter sized for the widest legal WIDTH so one package serves every instance.
  localparam int DIV_MAX_W = 64;
  localparam int DIV_CNT_W = $clog2(DIV_MAX_W + 1);

  function automatic logic [63:0] neg_w(input logic [63:0] v, input int w);
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (~v + 64'd1) & mask;
  endfunction

  function automatic logic [63:0] abs_w(input logic [63:0] v, input int w);
    logic [63:0] top;
    top = v >> (w - 1);
    return top[0] ? neg_w(v, w) : v;
  endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring shift-subtract divider, one quotient bit per cycle, signed or unsigned per
// operation, with valid/ready handshakes on both sides and a synchronous flush.
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dz
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // BUSY  | WIDTH shift/trial-subtract steps
  // FIXUP | apply result signs
  // DONE  | result held until out_ready

  div_state_t           r_state, w_state_nxt;
  logic [WIDTH:0]       r_rem;
  logic [WIDTH-1:0]     r_quo, r_div, r_q, r_r;
  logic                 r_neg_q, r_neg_r, r_dz;
  logic [DIV_CNT_W-1:0] r_cnt;

  logic             w_accept, w_div_zero, w_last, w_ge;
  logic [WIDTH-1:0] w_abs_y, w_abs_x, w_fix_q, w_fix_r;
  logic [WIDTH:0]   w_shift, w_diff;

  assign w_accept   = in_valid && (r_state == IDLE);
  assign w_div_zero = (divisor == '0);
  assign w_last     = (r_cnt == DIV_CNT_W'(WIDTH - 1));

  assign w_abs_y = in_signed ? WIDTH'(abs_w(64'(dividend), WIDTH)) : dividend;
  assign w_abs_x = in_signed ? WIDTH'(abs_w(64'(divisor), WIDTH)) : divisor;

  // The partial remainder stays below |x|, so its top bit is always clear before the shift.
  assign w_shift = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_div});
  assign w_diff  = w_shift - {1'b0, r_div};

  assign w_fix_q = r_neg_q ? WIDTH'(neg_w(64'(r_quo), WIDTH)) : r_quo;
  assign w_fix_r = WIDTH'(r_neg_r ? neg_w(64'(r_rem), WIDTH) : 64'(r_rem));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_div_zero ? DONE : BUSY;
      BUSY:    if (w_last) w_state_nxt = FIXUP;
      FIXUP:   w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
      r_dz    <= 1'b0;
    end else if (!flush) begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_neg_q <= in_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          r_neg_r <= in_signed & dividend[WIDTH-1];
          r_quo   <= w_abs_y;
          r_div   <= w_abs_x;
          r_rem   <= '0;
          r_cnt   <= '0;
          if (w_div_zero) begin
            r_q  <= '1;
            r_r  <= dividend;
            r_dz <= 1'b1;
          end
        end
        BUSY: begin
          r_cnt <= r_cnt + DIV_CNT_W'(1);
          r_rem <= w_ge ? w_diff : w_shift;
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
        end
        FIXUP: begin
          r_q  <= w_fix_q;
          r_r  <= w_fix_r;
          r_dz <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign q         = r_q;
  assign r         = r_r;
  assign dz        = r_dz;

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: WIDTH=8 and WIDTH=32 instances checked against an arithmetic
// reference on every DONE cycle, plus directed handshake, flush and reset scenarios.
module tb_div_iter;

  typedef struct packed {
    logic [63:0] q;
    logic [63:0] r;
    logic        dz;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        v8 = 0, ir8, sg8 = 0, ov8, ordy8 = 0, dz8, fl8 = 0;
  logic [7:0]  y8 = 0, x8 = 0, q8, r8;
  logic        v32 = 0, ir32, sg32 = 0, ov32, ordy32 = 0, dz32, fl32 = 0;
  logic [31:0] y32 = 0, x32 = 0, q32, r32;

  div_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(fl8), .in_valid(v8), .in_ready(ir8),
    .in_signed(sg8), .dividend(y8), .divisor(x8), .out_valid(ov8),
    .out_ready(ordy8), .q(q8), .r(r8), .dz(dz8)
  );

  div_iter #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(fl32), .in_valid(v32), .in_ready(ir32),
    .in_signed(sg32), .dividend(y32), .divisor(x32), .out_valid(ov32),
    .out_ready(ordy32), .q(q32), .r(r32), .dz(dz32)
  );

  int   n_assert = 0;
  int   n_fail = 0;
  res_t exp8, exp32;
  logic pend8 = 0, pend32 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division on sign-extended 64-bit values, folded back to w bits.
  function automatic res_t ref_div(input int w, input logic sgn, input logic [63:0] y_in,
                                   input logic [63:0] x_in);
    res_t        res;
    logic [63:0] mask, y, x;
    longint      sy, sx;
    mask = (64'd1 << w) - 64'd1;
    y = y_in & mask;
    x = x_in & mask;
    if (x == 0) begin
      res.q = mask; res.r = y; res.dz = 1'b1;
    end else if (sgn) begin
      sy = y[w-1] ? longint'(y | ~mask) : longint'(y);
      sx = x[w-1] ? longint'(x | ~mask) : longint'(x);
      res.q = 64'(sy / sx) & mask;
      res.r = 64'(sy % sx) & mask;
      res.dz = 1'b0;
    end else begin
      res.q = y / x; res.r = y % x; res.dz = 1'b0;
    end
    return res;
  endfunction

  always @(negedge clk) begin
    if (rst_n && ov8) begin
      if (!pend8) chk("valid8_without_op", 64'(pend8), 64'd1);
      else begin
        chk("q8", 64'(q8), exp8.q);
        chk("r8", 64'(r8), exp8.r);
        chk("dz8", 64'(dz8), 64'(exp8.dz));
      end
    end
    if (rst_n && ov32) begin
      if (!pend32) chk("valid32_without_op", 64'(pend32), 64'd1);
      else begin
        chk("q32", 64'(q32), exp32.q);
        chk("r32", 64'(r32), exp32.r);
        chk("dz32", 64'(dz32), 64'(exp32.dz));
      end
    end
  end

  function automatic logic get_ov(input int w); return (w == 8) ? ov8 : ov32; endfunction
  function automatic logic get_ir(input int w); return (w == 8) ? ir8 : ir32; endfunction
  function automatic logic [63:0] get_q(input int w); return (w == 8) ? 64'(q8) : 64'(q32); endfunction
  function automatic logic [63:0] get_r(input int w); return (w == 8) ? 64'(r8) : 64'(r32); endfunction

  task automatic drive(input int w, input logic v, input logic s, input logic [63:0] y,
                       input logic [63:0] x);
    if (w == 8) begin v8 = v; sg8 = s; y8 = y[7:0]; x8 = x[7:0]; end
    else begin v32 = v; sg32 = s; y32 = y[31:0]; x32 = x[31:0]; end
  endtask

  task automatic set_ordy(input int w, input logic val);
    if (w == 8) ordy8 = val; else ordy32 = val;
  endtask

  task automatic set_pend(input int w, input logic val, input res_t e);
    if (w == 8) begin exp8 = e; pend8 = val; end
    else begin exp32 = e; pend32 = val; end
  endtask

  task automatic op(input int w, input logic sgn, input logic [63:0] y, input logic [63:0] x,
                    input int hold);
    res_t e;
    int   lat;
    e = ref_div(w, sgn, y, x);
    chk($sformatf("in_ready_before_op_w%0d", w), 64'(get_ir(w)), 64'd1);
    set_pend(w, 1'b1, e);
    drive(w, 1'b1, sgn, y, x);
    @(posedge clk); #1;
    drive(w, 1'b0, 1'b1, {$urandom(), $urandom()}, {$urandom(), $urandom()});
    lat = 1;
    while (!get_ov(w) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("latency_w%0d", w), 64'(lat), e.dz ? 64'd1 : 64'(w + 2));
    if (!get_ov(w)) begin
      set_pend(w, 1'b0, e);
      return;
    end
    repeat (hold) begin
      @(posedge clk); #1;
      chk($sformatf("in_ready_low_in_done_w%0d", w), 64'(get_ir(w)), 64'd0);
      chk($sformatf("valid_held_w%0d", w), 64'(get_ov(w)), 64'd1);
    end
    set_ordy(w, 1'b1);
    @(posedge clk); #1;
    set_ordy(w, 1'b0);
    set_pend(w, 1'b0, e);
    chk($sformatf("idle_after_release_w%0d", w), 64'(get_ir(w)), 64'd1);
    chk($sformatf("valid_dropped_w%0d", w), 64'(get_ov(w)), 64'd0);
  endtask

  function automatic logic [63:0] pick(input int w);
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0:       v = 64'd0;
      1:       v = '1;
      2:       v = 64'd1;
      3:       v = 64'd1 << (w - 1);
      4:       v = 64'($urandom_range(0, 15));
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  initial begin
    res_t m;
    int   seen;

    #1 rst_n = 1'b0;
    #10;
    chk("rst_q32", 64'(q32), 64'd0);
    chk("rst_r32", 64'(r32), 64'd0);
    chk("rst_dz32", 64'(dz32), 64'd0);
    chk("rst_in_ready32", 64'(ir32), 64'd1);
    chk("rst_out_valid32", 64'(ov32), 64'd0);
    chk("rst_in_ready8", 64'(ir8), 64'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    m = ref_div(32, 1'b0, 64'd100, 64'd7);
    chk("model_100_7_q", m.q, 64'd14);
    chk("model_100_7_r", m.r, 64'd2);
    m = ref_div(32, 1'b1, 64'hFFFF_FFF9, 64'd2);
    chk("model_m7_2_q", m.q, 64'hFFFF_FFFD);
    chk("model_m7_2_r", m.r, 64'hFFFF_FFFF);
    m = ref_div(32, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF);
    chk("model_ovf_q", m.q, 64'h8000_0000);
    m = ref_div(8, 1'b1, 64'd200, 64'd0);
    chk("model_dz_q", m.q, 64'hFF);
    chk("model_dz_r", m.r, 64'd200);

    op(32, 1'b0, 64'd100, 64'd7, 0);
    chk("dut_100_7_q", get_q(32), 64'd14);
    chk("dut_100_7_r", get_r(32), 64'd2);
    chk("dut_100_7_dz", 64'(dz32), 64'd0);
    op(32, 1'b1, 64'hFFFF_FFF9, 64'd2, 0);
    chk("dut_m7_2_q", get_q(32), 64'hFFFF_FFFD);
    chk("dut_m7_2_r", get_r(32), 64'hFFFF_FFFF);
    op(32, 1'b1, 64'd7, 64'hFFFF_FFFE, 0);
    chk("dut_7_m2_q", get_q(32), 64'hFFFF_FFFD);
    chk("dut_7_m2_r", get_r(32), 64'd1);
    op(32, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 0);
    chk("dut_ovf_q", get_q(32), 64'h8000_0000);
    chk("dut_ovf_r", get_r(32), 64'd0);

    op(8, 1'b0, 64'd200, 64'd0, 0);
    chk("dut_dz_q", get_q(8), 64'hFF);
    chk("dut_dz_r", get_r(8), 64'd200);
    chk("dut_dz_flag", 64'(dz8), 64'd1);
    op(8, 1'b1, 64'd200, 64'd0, 0);
    chk("dut_dz_signed_r", get_r(8), 64'd200);
    op(8, 1'b0, 64'd255, 64'd1, 0);
    chk("dut_255_1_q", get_q(8), 64'd255);
    chk("dut_255_1_r", get_r(8), 64'd0);
    chk("dut_255_1_dz", 64'(dz8), 64'd0);

    op(32, 1'b0, 64'd1000, 64'd3, 10);
    chk("dut_stall_q", get_q(32), 64'd333);
    op(32, 1'b0, 64'd5, 64'd5, 0);
    chk("dut_second_q", get_q(32), 64'd1);

    fl32 = 1'b1;
    drive(32, 1'b1, 1'b0, 64'd50, 64'd5);
    @(posedge clk); #1;
    fl32 = 1'b0;
    drive(32, 1'b0, 1'b0, 64'd0, 64'd0);
    chk("flush_beats_accept", 64'(ir32), 64'd1);

    drive(32, 1'b1, 1'b0, 64'd123, 64'd4);
    @(posedge clk); #1;
    drive(32, 1'b0, 1'b0, 64'd0, 64'd0);
    repeat (10) begin @(posedge clk); #1; end
    chk("busy_before_flush", 64'(ir32), 64'd0);
    fl32 = 1'b1;
    @(posedge clk); #1;
    fl32 = 1'b0;
    chk("flush_to_idle", 64'(ir32), 64'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ov32) seen++;
    end
    chk("no_valid_after_flush", 64'(seen), 64'd0);
    op(32, 1'b0, 64'd9, 64'd3, 0);
    chk("dut_9_3_q", get_q(32), 64'd3);
    chk("dut_9_3_r", get_r(32), 64'd0);

    drive(32, 1'b1, 1'b0, 64'd77, 64'd5);
    @(posedge clk); #1;
    drive(32, 1'b0, 1'b0, 64'd0, 64'd0);
    repeat (5) begin @(posedge clk); #1; end
    #1 rst_n = 1'b0;
    #1;
    chk("midbusy_rst_q32", 64'(q32), 64'd0);
    chk("midbusy_rst_r32", 64'(r32), 64'd0);
    chk("midbusy_rst_in_ready32", 64'(ir32), 64'd1);
    chk("midbusy_rst_out_valid32", 64'(ov32), 64'd0);
    chk("midbusy_rst_q8", 64'(q8), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 500; i++)
      op(32, 1'($urandom_range(0, 1)), pick(32), pick(32), $urandom_range(0, 2));
    for (int i = 0; i < 500; i++)
      op(8, 1'($urandom_range(0, 1)), pick(8), pick(8), $urandom_range(0, 2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
